dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data-memory port between the single-cycle processor core (fixed priority, combinational access) and one secondary requester (test/debug loader or DMA) using a valid/ready handshake. The core is never delayed in normal operation. The secondary request is parked in a one-entry buffer and issued in the first cycle the core does not touch memory. An optional starvation guard can steal a slot by stalling the core. The block sits between the processor's `mem_read`/`mem_write`/`address`/`mem_write_data`/`mem_read_data` pins and the data memory, which has asynchronous read and synchronous write.

## Interface
- `MAX_WAIT`, 15: core-busy cycles a parked request tolerates before a slot is stolen. Only used with the starvation guard. Legal range 1–255.
- `clock` in 1: single clock; everything is rising-edge.
- `rst` in 1: **one clock; reset is asynchronous and active-high**.
- `cpu_mem_read` in 1: core load strobe.
- `cpu_mem_write` in 1: core store strobe.
- `cpu_address` in 32: core byte address.
- `cpu_write_data` in 32: core store data.
- `cpu_read_data` out 32: memory read data returned to the core (combinational).
- `cpu_stall` out 1: core hold request (PC and register writes frozen). Tied 0 without the guard.
- `sec_req_valid` in 1: secondary request valid.
- `sec_req_ready` out 1: arbiter can accept a request.
- `sec_req_write` in 1: 1 = store, 0 = load.
- `sec_req_addr` in 32: secondary byte address.
- `sec_req_wdata` in 32: secondary store data.
- `sec_rsp_valid` out 1: response available.
- `sec_rsp_ready` in 1: secondary consumes the response.
- `sec_rsp_rdata` out 32: load data; 0 for stores.
- `m_re` out 1: memory read enable.
- `m_we` out 1: memory write enable.
- `m_addr` out 32: memory address.
- `m_wdata` out 32: memory write data.
- `m_rdata` in 32: memory read data (asynchronous).

## Operation
- FSM states are IDLE, PENDING, RESP. Reset state is IDLE.
- IDLE
  - `sec_req_ready`=1.
  - When `sec_req_valid` is high at the edge: capture write, addr and wdata; clear `wait_cnt`; go to PENDING.
- PENDING
  - The slot is free when `!cpu_mem_read && !cpu_mem_write`.
  - Free slot: drive the memory from the buffer (`m_re`=!write, `m_we`=write). At the edge, capture `m_rdata` into `rsp_rdata` for loads (0 for stores), the store commits, and the FSM goes to RESP.
  - Busy slot: the core owns the port and `wait_cnt` increments, saturating at `MAX_WAIT`.
- RESP
  - `sec_rsp_valid`=1 and `sec_rsp_rdata` is held stable.
  - `rsp_ready` at the edge returns the FSM to IDLE.
- Core path outside a stolen slot: `m_*` = core signals; `cpu_read_data` = `m_rdata`.
- Muxed memory outputs are 0 when no owner is active (`m_re`=`m_we`=0, `m_addr`=`m_wdata`=0).
- Only one secondary transaction is outstanding at a time. There is no address translation; addresses pass through unmodified.

## Timing
- Reset values: `sec_req_ready`=1 (IDLE), `sec_rsp_valid`=0, `sec_rsp_rdata`=0, `cpu_stall`=0, `wait_cnt`=0.
- Minimum latency is 2 cycles from the accept edge to `sec_rsp_valid`: accept at edge N, issue in cycle N+1, valid from N+2.
- Each core-busy cycle in PENDING adds one cycle of latency.
- `sec_req_ready` is low in PENDING and RESP. A new request is accepted no earlier than the cycle after the response handshake.
- `sec_rsp_valid` stays high until `sec_rsp_ready`. Data must not change while valid.
- A core access in the same cycle the secondary would issue always wins; the secondary waits.
- Asynchronous `rst` mid-transaction drops the parked request with no memory write and clears the response. Outputs take their reset values immediately.

## Configuration
- `DMEM_ARB_STARVE_EN` defined: starvation guard is compiled in.
  - In PENDING with `wait_cnt`==`MAX_WAIT` and the core busy, `cpu_stall`=1 (combinational) for exactly that cycle.
  - In that cycle the secondary drives the memory, core `m_we` is masked, and `cpu_read_data`=0.
  - Worst-case latency becomes `MAX_WAIT`+2.
- Undefined: `cpu_stall` is tied 0, there is no `wait_cnt` register, and the secondary waits unboundedly.

## Structure
- Shared package `dmem_arb_pkg`:
  - state enum (IDLE, PENDING, RESP);
  - `DMEM_AW`=32 and `DMEM_DW`=32;
  - request-buffer struct (write, addr, wdata).
- No sub-module. The FSM, buffer and output mux are one module. The wait counter sits inside the macro guard.

## Test plan
- Core idle; secondary store addr 0x100, data 0xCAFEBABE → `m_we`=1 one cycle after accept with those values; `sec_rsp_valid` the next cycle with rdata 0.
- Secondary load 0x100 after that store, core idle → `m_re`=1 one cycle after accept; rsp_rdata 0xCAFEBABE at accept+2.
- Core loads on 5 consecutive cycles while a secondary load is parked → core sees correct data each cycle; secondary issues on cycle 6; latency 7 cycles.
- Guard enabled, `MAX_WAIT`=3, core busy continuously:
  - `cpu_stall`=1 exactly on the 4th PENDING cycle;
  - core store masked that cycle;
  - response follows next cycle.
- `rst` pulsed while a store is PENDING → no `m_we` pulse, `sec_req_ready`=1, `sec_rsp_valid`=0 immediately.
- Response backpressure: `sec_rsp_ready` held 0 for 4 cycles → rsp stays valid with stable data, `sec_req_ready`=0 throughout; IDLE after the handshake.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Request buffer layout, FSM states and bus widths.
package dmem_arb_pkg;

  localparam int DMEM_AW = 32;
  localparam int DMEM_DW = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    RESP    = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic               write;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
  } req_buf_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core first, secondary via one-entry buffer.
// Define DMEM_ARB_STARVE_EN to compile in the starvation guard.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               cpu_mem_read,
  input  logic               cpu_mem_write,
  input  logic [DMEM_AW-1:0] cpu_address,
  input  logic [DMEM_DW-1:0] cpu_write_data,
  output logic [DMEM_DW-1:0] cpu_read_data,
  output logic               cpu_stall,
  input  logic               sec_req_valid,
  output logic               sec_req_ready,
  input  logic               sec_req_write,
  input  logic [DMEM_AW-1:0] sec_req_addr,
  input  logic [DMEM_DW-1:0] sec_req_wdata,
  output logic               sec_rsp_valid,
  input  logic               sec_rsp_ready,
  output logic [DMEM_DW-1:0] sec_rsp_rdata,
  output logic               m_re,
  output logic               m_we,
  output logic [DMEM_AW-1:0] m_addr,
  output logic [DMEM_DW-1:0] m_wdata,
  input  logic [DMEM_DW-1:0] m_rdata
);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("dmem_arbiter: MAX_WAIT out of range");
  end

  arb_state_e         state_q, state_d;
  req_buf_t           buf_q, buf_d;
  logic [DMEM_DW-1:0] rsp_rdata_q, rsp_rdata_d;

  logic core_busy;
  logic pending;
  logic steal;
  logic issue;

  assign core_busy = cpu_mem_read | cpu_mem_write;
  assign pending   = (state_q == PENDING);

`ifdef DMEM_ARB_STARVE_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;

  assign steal = pending & core_busy &
                 (wait_cnt_q == 8'(MAX_WAIT));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == IDLE && sec_req_valid) begin
      wait_cnt_d = '0;
    end else if (pending && core_busy && !steal) begin
      if (wait_cnt_q < 8'(MAX_WAIT)) begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign steal = 1'b0;
`endif

  // A stolen slot counts as an issue even though the core is busy.
  assign issue = pending & (~core_busy | steal);

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (sec_req_valid) begin
          buf_d.write = sec_req_write;
          buf_d.addr  = sec_req_addr;
          buf_d.wdata = sec_req_wdata;
          state_d     = PENDING;
        end
      end
      PENDING: begin
        if (issue) begin
          rsp_rdata_d = buf_q.write ? '0 : m_rdata;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (sec_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    m_re    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (issue) begin
      m_re    = ~buf_q.write;
      m_we    = buf_q.write;
      m_addr  = buf_q.addr;
      m_wdata = buf_q.write ? buf_q.wdata : '0;
    end else if (core_busy) begin
      m_re    = cpu_mem_read;
      m_we    = cpu_mem_write;
      m_addr  = cpu_address;
      m_wdata = cpu_write_data;
    end
  end

  assign cpu_read_data = steal ? '0 : m_rdata;
  assign cpu_stall     = steal;
  assign sec_req_ready = (state_q == IDLE);
  assign sec_rsp_valid = (state_q == RESP);
  assign sec_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a scoreboard of
// expected secondary responses and a behavioural data memory.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        rst;
  logic        cpu_mem_read, cpu_mem_write;
  logic [31:0] cpu_address, cpu_write_data, cpu_read_data;
  logic        cpu_stall;
  logic        sec_req_valid, sec_req_ready, sec_req_write;
  logic [31:0] sec_req_addr, sec_req_wdata;
  logic        sec_rsp_valid, sec_rsp_ready;
  logic [31:0] sec_rsp_rdata;
  logic        m_re, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;

  dmem_arbiter #(.MAX_WAIT(3)) dut (
    .clock          (clock),
    .rst            (rst),
    .cpu_mem_read   (cpu_mem_read),
    .cpu_mem_write  (cpu_mem_write),
    .cpu_address    (cpu_address),
    .cpu_write_data (cpu_write_data),
    .cpu_read_data  (cpu_read_data),
    .cpu_stall      (cpu_stall),
    .sec_req_valid  (sec_req_valid),
    .sec_req_ready  (sec_req_ready),
    .sec_req_write  (sec_req_write),
    .sec_req_addr   (sec_req_addr),
    .sec_req_wdata  (sec_req_wdata),
    .sec_rsp_valid  (sec_rsp_valid),
    .sec_rsp_ready  (sec_rsp_ready),
    .sec_rsp_rdata  (sec_rsp_rdata),
    .m_re           (m_re),
    .m_we           (m_we),
    .m_addr         (m_addr),
    .m_wdata        (m_wdata),
    .m_rdata        (m_rdata)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [0:255];
  logic        mem_clr;

  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (m_we) begin
      mem[m_addr[9:2]] <= m_wdata;
    end
  end

  assign m_rdata = mem[m_addr[9:2]];

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] sb_q [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic sec_put(input logic w,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [31:0] exp);
    sec_req_valid = 1'b1;
    sec_req_write = w;
    sec_req_addr  = a;
    sec_req_wdata = d;
    #1 chk("req_ready_accept", 32'(sec_req_ready), 1);
    sb_q.push_back(exp);
    cyc();
    sec_req_valid = 1'b0;
    sec_req_write = 1'b0;
    sec_req_addr  = '0;
    sec_req_wdata = '0;
  endtask

  task automatic rsp_take(input int budget, output int lat);
    logic [31:0] exp;
    int k;
    k = 0;
    #1;
    while (!sec_rsp_valid && k < budget) begin
      cyc();
      #1;
      k++;
    end
    lat = k;
    if (!sec_rsp_valid) begin
      chk("rsp_timeout", 32'(sec_rsp_valid), 1);
    end else if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'(sb_q.size()), 1);
    end else begin
      exp = sb_q.pop_front();
      chk("rsp_rdata", sec_rsp_rdata, exp);
      sec_rsp_ready = 1'b1;
      cyc();
      sec_rsp_ready = 1'b0;
      #1;
      chk("idle_after_hs", 32'(sec_req_ready), 1);
      chk("valid_after_hs", 32'(sec_rsp_valid), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1;
    mem_clr = 1'b1;
    cpu_mem_read = 0; cpu_mem_write = 0;
    cpu_address = '0; cpu_write_data = '0;
    sec_req_valid = 0; sec_req_write = 0;
    sec_req_addr = '0; sec_req_wdata = '0;
    sec_rsp_ready = 0;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_req_ready", 32'(sec_req_ready), 1);
    chk("rst_rsp_valid", 32'(sec_rsp_valid), 0);
    chk("rst_rsp_rdata", sec_rsp_rdata, 0);
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_m_we", 32'(m_we), 0);
    chk("rst_m_addr", m_addr, 0);
    cyc();
    rst = 1'b0;
    mem_clr = 1'b0;

    // secondary store, core idle
    sec_put(1'b1, 32'h100, 32'hCAFEBABE, 32'h0);
    #1;
    chk("st_m_we", 32'(m_we), 1);
    chk("st_m_re", 32'(m_re), 0);
    chk("st_m_addr", m_addr, 32'h100);
    chk("st_m_wdata", m_wdata, 32'hCAFEBABE);
    chk("st_req_ready", 32'(sec_req_ready), 0);
    chk("st_rsp_early", 32'(sec_rsp_valid), 0);
    cyc();
    rsp_take(4, lat);
    chk("st_lat", 32'(lat), 0);
    cyc();

    // secondary load of the stored word
    sec_put(1'b0, 32'h100, 32'h0, 32'hCAFEBABE);
    #1;
    chk("ld_m_re", 32'(m_re), 1);
    chk("ld_m_we", 32'(m_we), 0);
    chk("ld_m_addr", m_addr, 32'h100);
    cyc();
    rsp_take(4, lat);
    chk("ld_lat", 32'(lat), 0);
    cyc();

    // core stores to seed a table
    for (int i = 0; i < 5; i++) begin
      cpu_mem_write = 1'b1;
      cpu_address = 32'h200 + 32'(4 * i);
      cpu_write_data = 32'h11110000 + 32'(i);
      #1;
      chk("core_wr_we", 32'(m_we), 1);
      chk("core_wr_addr", m_addr, 32'h200 + 32'(4 * i));
      cyc();
    end
    cpu_mem_write = 1'b0;
    cpu_address = '0;
    cpu_write_data = '0;

    // parked load while the core reads five cycles
    sec_put(1'b0, 32'h100, 32'h0, 32'hCAFEBABE);
    for (int i = 0; i < 5; i++) begin
      cpu_mem_read = 1'b1;
      cpu_address = 32'h200 + 32'(4 * i);
      #1;
      chk("core_rd_data", cpu_read_data,
          32'h11110000 + 32'(i));
      chk("core_rd_addr", m_addr, 32'h200 + 32'(4 * i));
      chk("core_rd_rspv", 32'(sec_rsp_valid), 0);
      chk("core_rd_stall", 32'(cpu_stall), 0);
      cyc();
    end
    cpu_mem_read = 1'b0;
    cpu_address = '0;
    #1;
    chk("park_issue_re", 32'(m_re), 1);
    chk("park_issue_addr", m_addr, 32'h100);
    cyc();
    rsp_take(4, lat);
    chk("park_lat", 32'(lat), 0);
    cyc();

    // core busy continuously with a parked store
    sec_put(1'b1, 32'h300, 32'hA5A55A5A, 32'h0);
`ifdef DMEM_ARB_STARVE_EN
    for (int i = 1; i <= 4; i++) begin
      cpu_mem_write = 1'b1;
      cpu_address = 32'h304;
      cpu_write_data = (i == 4) ? 32'hDEAD0000
                                : 32'h300 + 32'(i);
      #1;
      chk("guard_stall", 32'(cpu_stall), 32'(i == 4));
      if (i == 4) begin
        chk("steal_addr", m_addr, 32'h300);
        chk("steal_wdata", m_wdata, 32'hA5A55A5A);
        chk("steal_rdata", cpu_read_data, 0);
      end else begin
        chk("guard_core_addr", m_addr, 32'h304);
      end
      cyc();
    end
    cpu_mem_write = 1'b0;
    cpu_address = '0;
    cpu_write_data = '0;
    rsp_take(4, lat);
    chk("guard_lat", 32'(lat), 0);
    chk("guard_masked", mem[8'hC1], 32'h303);
`else
    for (int i = 1; i <= 8; i++) begin
      cpu_mem_write = 1'b1;
      cpu_address = 32'h304;
      cpu_write_data = 32'h300 + 32'(i);
      #1;
      chk("noguard_stall", 32'(cpu_stall), 0);
      chk("noguard_addr", m_addr, 32'h304);
      chk("noguard_rspv", 32'(sec_rsp_valid), 0);
      cyc();
    end
    cpu_mem_write = 1'b0;
    cpu_address = '0;
    cpu_write_data = '0;
    #1;
    chk("noguard_issue", m_addr, 32'h300);
    cyc();
    rsp_take(4, lat);
    chk("noguard_lat", 32'(lat), 0);
    chk("noguard_core", mem[8'hC1], 32'h308);
`endif
    chk("sec_store_mem", mem[8'hC0], 32'hA5A55A5A);
    cyc();

    // async reset drops a parked store
    sec_put(1'b1, 32'h0C0, 32'h77777777, 32'h0);
    cpu_mem_read = 1'b1;
    cpu_address = 32'h200;
    #1;
    chk("rst_pend_core", m_addr, 32'h200);
    cpu_mem_read = 1'b0;
    cpu_address = '0;
    rst = 1'b1;
    #1;
    chk("arst_req_ready", 32'(sec_req_ready), 1);
    chk("arst_rsp_valid", 32'(sec_rsp_valid), 0);
    chk("arst_m_we", 32'(m_we), 0);
    cyc();
    cyc();
    rst = 1'b0;
    void'(sb_q.pop_back());
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_rst_we", 32'(m_we), 0);
      chk("post_rst_addr", m_addr, 0);
      chk("post_rst_ready", 32'(sec_req_ready), 1);
      cyc();
    end
    chk("dropped_store", mem[8'h30], 32'h0);

    // response backpressure
    sec_put(1'b0, 32'h204, 32'h0, 32'h11110001);
    #1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      cpu_mem_read = (i == 2);
      cpu_address = (i == 2) ? 32'h208 : 32'h0;
      #1;
      chk("bp_valid", 32'(sec_rsp_valid), 1);
      chk("bp_rdata", sec_rsp_rdata, 32'h11110001);
      chk("bp_req_ready", 32'(sec_req_ready), 0);
      if (i == 2) chk("bp_core_rd", cpu_read_data, 32'h11110002);
      cyc();
    end
    cpu_mem_read = 1'b0;
    cpu_address = '0;
    rsp_take(2, lat);
    chk("bp_lat", 32'(lat), 0);
    chk("sb_drained", 32'(sb_q.size()), 0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
